// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : disp_pkg
// Brief   : Shared types and character constants for the guessing-game
//           LCD formatter (state enum, ASCII codes, banner strings).
// Rev     : 1.0  initial release
// ============================================================================
package disp_pkg;

  typedef enum logic [0:0] {
    PLAY   = 1'b0,
    RESULT = 1'b1
  } state_e;

  localparam logic [7:0] SPACE      = 8'h20;
  localparam logic [7:0] UNDERSCORE = 8'h5F;

  localparam int WIN_LEN  = 8;
  localparam int LOSE_LEN = 9;

  localparam logic [WIN_LEN*8-1:0]  WIN_STR  = "YOU WIN!";
  localparam logic [LOSE_LEN*8-1:0] LOSE_STR = "GAME OVER";

  // Character k (0 = leftmost) of the selected banner; caller keeps k in range.
  function automatic logic [7:0] banner_char(input logic is_win, input int k);
    if (is_win) begin
      return WIN_STR[(WIN_LEN-1-k)*8 +: 8];
    end
    return LOSE_STR[(LOSE_LEN-1-k)*8 +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/guess_history.sv
`default_nettype none
// ============================================================================
// Module  : guess_history
// Brief   : Ordered, duplicate-free guess store. Appends until full, then
//           shifts out the oldest entry. Clear restores all slots to '_'.
// Rev     : 1.0  initial release
// ============================================================================
module guess_history
  import disp_pkg::*;
#(
  parameter  int SLOTS = 10,
  localparam int CW    = $clog2(SLOTS+1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              push,
  input  logic              clear,
  input  logic [7:0]        din,
  output logic [SLOTS*8-1:0] slots,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              is_dup
);

  logic [7:0]    slot_q [SLOTS];
  logic [7:0]    slot_d [SLOTS];
  logic [CW-1:0] count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(SLOTS));

  // Flatten storage; slot i occupies byte [i*8 +: 8].
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_pack
    assign slots[gi*8 +: 8] = slot_q[gi];
  end

  // Incoming character matches one of the currently valid slots.
  always_comb begin
    is_dup = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if ((CW'(i) < count_q) && (slot_q[i] == din)) begin
        is_dup = 1'b1;
      end
    end
  end

  // Next history: clear wins, then append or shift-on-full for new guesses.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < SLOTS; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (clear) begin
      count_d = '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_d[i] = UNDERSCORE;
      end
    end else if (push && !is_dup) begin
      if (!full) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (CW'(i) == count_q) begin
            slot_d[i] = din;
          end
        end
        count_d = count_q + 1'b1;
      end else begin
        for (int i = 0; i < SLOTS-1; i++) begin
          slot_d[i] = slot_q[i+1];
        end
        slot_d[SLOTS-1] = din;
      end
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= UNDERSCORE;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/guess_display.sv
`default_nettype none
// ============================================================================
// Module  : guess_display
// Brief   : Two-row LCD formatter for the guessing game. Row 1 shows the live
//           selection or a timed win/lose banner; row 2 shows guess history.
// Rev     : 1.0  initial release
// ============================================================================
module guess_display
  import disp_pkg::*;
#(
  parameter  int COLS        = 16,
  parameter  int SLOTS       = 10,
  parameter  int HOLD_CYCLES = 50_000_000,
  localparam int CW          = $clog2(SLOTS+1)
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               ready,
  input  logic [7:0]         msg,
  input  logic               gameEnd,
  input  logic               win,
  output logic [COLS*8-1:0]  row1,
  output logic [COLS*8-1:0]  row2,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               dup
);

  localparam int HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LP       = (COLS - SLOTS) / 2;
  localparam int MSG_COL  = COLS / 2;
  localparam int WIN_COL  = (COLS - WIN_LEN) / 2;
  localparam int LOSE_COL = (COLS - LOSE_LEN) / 2;

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              win_q, win_d;
  logic              dup_q, dup_d;
  logic              push_w;
  logic              clear_w;
  logic              is_dup_w;
  logic [SLOTS*8-1:0] slots_w;

  assign dup = dup_q;

  guess_history #(
    .SLOTS (SLOTS)
  ) u_history (
    .clk    (clk),
    .nRst   (nRst),
    .push   (push_w),
    .clear  (clear_w),
    .din    (msg),
    .slots  (slots_w),
    .count  (count),
    .full   (full),
    .is_dup (is_dup_w)
  );

  // Next-state logic: guesses accepted only in PLAY without a concurrent
  // end-of-round; RESULT counts down the banner hold then clears history.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    win_d   = win_q;
    push_w  = 1'b0;
    clear_w = 1'b0;
    dup_d   = 1'b0;
    case (state_q)
      PLAY: begin
        if (gameEnd) begin
          win_d   = win;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = RESULT;
        end else if (ready) begin
          push_w = 1'b1;
          dup_d  = is_dup_w;
        end
      end
      RESULT: begin
        if (hold_q == '0) begin
          clear_w = 1'b1;
          state_d = PLAY;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // State, hold counter, latched outcome and duplicate pulse.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= PLAY;
      hold_q  <= '0;
      win_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      dup_q   <= dup_d;
    end
  end

  // Top row: live selection in the middle during play, centred banner after.
  always_comb begin
    row1 = {COLS{SPACE}};
    for (int c = 0; c < COLS; c++) begin
      if (state_q == PLAY) begin
        if (c == MSG_COL) begin
          row1[(COLS-c)*8-1 -: 8] = msg;
        end
      end else if (win_q) begin
        if ((c >= WIN_COL) && (c < WIN_COL + WIN_LEN)) begin
          row1[(COLS-c)*8-1 -: 8] = banner_char(1'b1, c - WIN_COL);
        end
      end else begin
        if ((c >= LOSE_COL) && (c < LOSE_COL + LOSE_LEN)) begin
          row1[(COLS-c)*8-1 -: 8] = banner_char(1'b0, c - LOSE_COL);
        end
      end
    end
  end

  // Bottom row: history slots centred with space padding on both sides.
  always_comb begin
    row2 = {COLS{SPACE}};
    for (int c = 0; c < COLS; c++) begin
      if ((c >= LP) && (c < LP + SLOTS)) begin
        row2[(COLS-c)*8-1 -: 8] = slots_w[(c-LP)*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_guess_display.sv
`default_nettype none
// ============================================================================
// Module  : tb_guess_display
// Brief   : Self-checking bench for guess_display (COLS=16, SLOTS=10,
//           HOLD_CYCLES=4) against a queue-based behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_guess_display;

  localparam int COLS  = 16;
  localparam int SLOTS = 10;
  localparam int HOLD  = 4;

  logic         clk     = 1'b0;
  logic         nRst    = 1'b0;
  logic         ready   = 1'b0;
  logic         gameEnd = 1'b0;
  logic         win     = 1'b0;
  logic [7:0]   msg     = 8'h41;
  logic [127:0] row1, row2;
  logic [3:0]   count;
  logic         full, dup;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  byte unsigned hist[$];
  bit           in_res  = 1'b0;
  int           res_cyc = 0;
  bit           w_flag  = 1'b0;
  bit           exp_dup = 1'b0;

  guess_display #(
    .COLS        (COLS),
    .SLOTS       (SLOTS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .nRst    (nRst),
    .ready   (ready),
    .msg     (msg),
    .gameEnd (gameEnd),
    .win     (win),
    .row1    (row1),
    .row2    (row2),
    .count   (count),
    .full    (full),
    .dup     (dup)
  );

  always #5 clk = ~clk;

  // Model update: history as an ordered queue, result phase as elapsed cycles.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hist.delete();
      in_res  = 1'b0;
      res_cyc = 0;
      w_flag  = 1'b0;
      exp_dup = 1'b0;
    end else if (in_res) begin
      exp_dup = 1'b0;
      res_cyc++;
      if (res_cyc == HOLD) begin
        in_res = 1'b0;
        hist.delete();
      end
    end else if (gameEnd) begin
      in_res  = 1'b1;
      res_cyc = 0;
      w_flag  = win;
      exp_dup = 1'b0;
    end else if (ready) begin
      bit seen;
      seen = 1'b0;
      foreach (hist[i]) if (hist[i] == msg) seen = 1'b1;
      exp_dup = seen;
      if (!seen) begin
        if (hist.size() == SLOTS) void'(hist.pop_front());
        hist.push_back(msg);
      end
    end else begin
      exp_dup = 1'b0;
    end
  end

  function automatic logic [127:0] put(input logic [127:0] r, input int col,
                                       input logic [7:0] ch);
    logic [127:0] t;
    t = r;
    t[(COLS-col)*8-1 -: 8] = ch;
    return t;
  endfunction

  function automatic logic [127:0] exp_row1();
    logic [127:0] r;
    string        b;
    int           st;
    r = {COLS{8'h20}};
    if (!in_res) begin
      r = put(r, COLS/2, msg);
    end else begin
      b  = w_flag ? "YOU WIN!" : "GAME OVER";
      st = (COLS - b.len()) / 2;
      for (int k = 0; k < b.len(); k++) r = put(r, st + k, b.getc(k));
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_row2();
    logic [127:0] r;
    r = {COLS{8'h20}};
    for (int i = 0; i < SLOTS; i++) begin
      r = put(r, 3 + i, (i < hist.size()) ? hist[i] : 8'h5F);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always begin
    @(negedge clk);
    #2;
    check("row1",  row1, exp_row1());
    check("row2",  row2, exp_row2());
    check("count", 128'(count), 128'(hist.size()));
    check("full",  128'(full), 128'(hist.size() == SLOTS));
    check("dup",   128'(dup), 128'(exp_dup));
  end

  task automatic drive(input logic r, input logic [7:0] m, input logic ge,
                       input logic w);
    @(negedge clk);
    #1;
    ready   = r;
    msg     = m;
    gameEnd = ge;
    win     = w;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 nRst = 1'b0;
    @(negedge clk);
    #1 nRst = 1'b1;
  endtask

  logic [127:0] lit;

  initial begin
    repeat (2) @(negedge clk);
    #1 nRst = 1'b1;
    #2;
    lit = "        A       ";
    check("rst_row1", row1, lit);
    lit = "   __________   ";
    check("rst_row2", row2, lit);
    check("rst_count", 128'(count), 128'(0));

    drive(1'b1, "C", 1'b0, 1'b0);
    drive(1'b1, "A", 1'b0, 1'b0);
    drive(1'b1, "T", 1'b0, 1'b0);
    drive(1'b0, "Q", 1'b0, 1'b0);
    #2;
    lit = "   CAT_______   ";
    check("cat_row2", row2, lit);
    check("cat_count", 128'(count), 128'(3));
    check("cat_full", 128'(full), 128'(0));

    drive(1'b1, "A", 1'b0, 1'b0);
    drive(1'b0, "Q", 1'b0, 1'b0);
    #2;
    check("dup_hi", 128'(dup), 128'(1));
    check("dup_count", 128'(count), 128'(3));
    check("dup_row2", row2, lit);
    drive(1'b0, "Q", 1'b0, 1'b0);
    #2;
    check("dup_lo", 128'(dup), 128'(0));

    pulse_reset();
    for (int k = 0; k < 11; k++) drive(1'b1, 8'(8'h41 + k), 1'b0, 1'b0);
    drive(1'b0, "Q", 1'b0, 1'b0);
    #2;
    lit = "   BCDEFGHIJK   ";
    check("shift_row2", row2, lit);
    check("shift_count", 128'(count), 128'(10));
    check("shift_full", 128'(full), 128'(1));

    drive(1'b1, "Z", 1'b1, 1'b1);
    for (int k = 0; k < HOLD; k++) begin
      drive(1'($urandom_range(0, 1)), 8'(8'h41 + $urandom_range(0, 25)), 1'b0, 1'b0);
      #2;
      lit = "    YOU WIN!    ";
      check("win_banner", row1, lit);
      lit = "   BCDEFGHIJK   ";
      check("win_hist", row2, lit);
    end
    drive(1'b0, "B", 1'b0, 1'b0);
    #2;
    lit = "        B       ";
    check("post_win_row1", row1, lit);
    lit = "   __________   ";
    check("post_win_row2", row2, lit);
    check("post_win_count", 128'(count), 128'(0));

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) pulse_reset();
      drive(1'($urandom_range(0, 1)), 8'(8'h41 + $urandom_range(0, 13)),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (HOLD + 2) drive(1'b0, "A", 1'b0, 1'b0);
    drive(1'b0, "A", 1'b1, 1'b0);
    drive(1'b0, "M", 1'b0, 1'b0);
    #2;
    lit = "   GAME OVER    ";
    check("lose_banner", row1, lit);
    @(negedge clk);
    #1 nRst = 1'b0;
    #2;
    lit = "        M       ";
    check("rst_mid_row1", row1, lit);
    lit = "   __________   ";
    check("rst_mid_row2", row2, lit);
    check("rst_mid_count", 128'(count), 128'(0));
    check("rst_mid_dup", 128'(dup), 128'(0));
    @(negedge clk);
    #1 nRst = 1'b1;
    repeat (2) drive(1'b0, "A", 1'b0, 1'b0);
    @(negedge clk);
    #3;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
